// File: rtl/dst_port_demux_pkg.sv
// Shared IOQ header constants and demux FSM encoding used by the dst_port_demux slice.
package dst_port_demux_pkg;

    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;
    localparam int         IOQ_DST_PORT_POS   = 0;

    typedef enum logic [2:0] {
        WAIT_HDR  = 3'd0,
        SEND_HDRS = 3'd1,
        SEND_DATA = 3'd2,
        DROP_HDRS = 3'd3,
        DROP_DATA = 3'd4
    } demux_state_t;

endpackage

// File: rtl/dst_port_demux_stats.sv
// Per-output-port forwarded-packet counters (built only with DST_PORT_DEMUX_STATS_EN).
module dst_port_demux_stats #(
    parameter int NUM_PORTS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   inc,
    output logic [32*NUM_PORTS-1:0] pkt_cnt
);
    logic [31:0] cnt_reg [NUM_PORTS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (reset) begin
                cnt_reg[i] <= '0;
            end else if (inc[i]) begin
                cnt_reg[i] <= cnt_reg[i] + 32'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_flat
            assign pkt_cnt[32*gi +: 32] = cnt_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/small_fifo.sv
// Show-ahead FIFO: the head entry is visible on dout the cycle after it is written.
module small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3,
    parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 2**MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_COUNT = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NF_COUNT   = (MAX_DEPTH_BITS+1)'(NEARLY_FULL);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_reg;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_reg;
    logic [MAX_DEPTH_BITS:0]   depth_reg;
    logic                      full;
    logic                      wr_ok;
    logic                      rd_ok;

    assign full        = (depth_reg == FULL_COUNT);
    assign empty       = (depth_reg == '0);
    assign nearly_full = (depth_reg >= NF_COUNT);
    // A write into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign wr_ok       = wr_en && (!full || rd_en);
    assign rd_ok       = rd_en && !empty;
    assign dout        = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            depth_reg  <= '0;
        end else begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + MAX_DEPTH_BITS'(1);
            if (rd_ok) rd_ptr_reg <= rd_ptr_reg + MAX_DEPTH_BITS'(1);
            if (wr_ok && !rd_ok)      depth_reg <= depth_reg + (MAX_DEPTH_BITS+1)'(1);
            else if (!wr_ok && rd_ok) depth_reg <= depth_reg - (MAX_DEPTH_BITS+1)'(1);
        end
    end

endmodule

// File: rtl/dst_port_demux.sv
// Steers IOQ-headed packets to the output ports named in the header bitmap (multicast, drop).
// Optional per-port packet counters are built when DST_PORT_DEMUX_STATS_EN is defined.
module dst_port_demux
    import dst_port_demux_pkg::*;
#(
    parameter int DATA_WIDTH         = 64,
    parameter int CTRL_WIDTH         = DATA_WIDTH/8,
    parameter int NUM_OUTPUT_QUEUES  = 8,
    parameter int IN_FIFO_DEPTH_BITS = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic [NUM_OUTPUT_QUEUES-1:0] out_wr,
    input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
    output logic [31:0]                  drop_cnt
`ifdef DST_PORT_DEMUX_STATS_EN
    ,
    output logic [32*NUM_OUTPUT_QUEUES-1:0] pkt_cnt
`endif
);
    logic [DATA_WIDTH-1:0]        head_data;
    logic [CTRL_WIDTH-1:0]        head_ctrl;
    logic                         fifo_empty;
    logic                         fifo_nearly_full;
    logic                         fifo_rd;
    logic [NUM_OUTPUT_QUEUES-1:0] head_sel;
    logic [NUM_OUTPUT_QUEUES-1:0] sel_reg;
    demux_state_t                 state_reg;
    logic                         head_is_ioq;
    logic                         sending;
    logic                         dropping;
    logic                         ports_ready;
    logic                         fire;
    logic                         discard;

    small_fifo #(
        .WIDTH          (DATA_WIDTH + CTRL_WIDTH),
        .MAX_DEPTH_BITS (IN_FIFO_DEPTH_BITS)
    ) in_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (fifo_rd),
        .dout        ({head_ctrl, head_data}),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign in_rdy      = !fifo_nearly_full;
    assign head_sel    = head_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES];
    assign head_is_ioq = (head_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));
    assign sending     = (state_reg == SEND_HDRS) || (state_reg == SEND_DATA);
    assign dropping    = (state_reg == DROP_HDRS) || (state_reg == DROP_DATA);
    // All selected ports must be ready together: multicast never splits a word across cycles.
    assign ports_ready = &(out_rdy | ~sel_reg);
    assign fire        = sending && !fifo_empty && ports_ready;
    assign discard     = dropping && !fifo_empty;
    assign fifo_rd     = fire || discard;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= WAIT_HDR;
            sel_reg   <= '0;
            out_wr    <= '0;
            out_data  <= '0;
            out_ctrl  <= '0;
            drop_cnt  <= '0;
        end else begin
            out_wr <= fire ? sel_reg : '0;
            if (fire) begin
                out_data <= head_data;
                out_ctrl <= head_ctrl;
            end
            case (state_reg)
                WAIT_HDR: begin
                    if (!fifo_empty) begin
                        if (head_is_ioq && (head_sel != '0)) begin
                            sel_reg   <= head_sel;
                            state_reg <= SEND_HDRS;
                        end else begin
                            state_reg <= DROP_HDRS;
                        end
                    end
                end
                SEND_HDRS: if (fire && (head_ctrl == '0)) state_reg <= SEND_DATA;
                SEND_DATA: if (fire && (head_ctrl != '0)) state_reg <= WAIT_HDR;
                DROP_HDRS: if (discard && (head_ctrl == '0)) state_reg <= DROP_DATA;
                DROP_DATA: begin
                    if (discard && (head_ctrl != '0)) begin
                        drop_cnt  <= drop_cnt + 32'd1;
                        state_reg <= WAIT_HDR;
                    end
                end
                default: state_reg <= WAIT_HDR;
            endcase
        end
    end

`ifdef DST_PORT_DEMUX_STATS_EN
    logic                         pkt_done;
    logic [NUM_OUTPUT_QUEUES-1:0] cnt_inc;

    assign pkt_done = fire && (state_reg == SEND_DATA) && (head_ctrl != '0);
    assign cnt_inc  = pkt_done ? sel_reg : '0;

    dst_port_demux_stats #(
        .NUM_PORTS (NUM_OUTPUT_QUEUES)
    ) stats (
        .clk     (clk),
        .reset   (reset),
        .inc     (cnt_inc),
        .pkt_cnt (pkt_cnt)
    );
`endif

endmodule

// File: tb/tb_dst_port_demux.sv
// Scoreboard bench for dst_port_demux: expected strobes queued at drive time, checked at negedge.
module tb_dst_port_demux;
    import dst_port_demux_pkg::*;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 8;

    typedef struct packed {
        logic [NQ-1:0] ports;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_wr;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [NQ-1:0] out_wr;
    logic [NQ-1:0] out_rdy;
    logic [31:0]   drop_cnt;
`ifdef DST_PORT_DEMUX_STATS_EN
    logic [32*NQ-1:0] pkt_cnt;
`endif

    dst_port_demux #(
        .DATA_WIDTH         (DW),
        .CTRL_WIDTH         (CW),
        .NUM_OUTPUT_QUEUES  (NQ),
        .IN_FIFO_DEPTH_BITS (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .out_rdy  (out_rdy),
        .drop_cnt (drop_cnt)
`ifdef DST_PORT_DEMUX_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   hdr_cyc = 0;
    int   last_wr_cyc = 0;
    int   n_writes = 0;
    int   model_drop = 0;
    int   model_pkt [NQ];
    int   recv_cnt [NQ];
    exp_t sb [$];
    exp_t mon_e;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Every strobe must match the oldest expected word, including which ports it went to.
    initial forever begin
        @(negedge clk);
        if (out_wr != '0) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL stream_unexpected: out_wr=%b ctrl=%h data=%h, required no strobe", out_wr, out_ctrl, out_data);
            end else begin
                mon_e = sb.pop_front();
                if (out_wr !== mon_e.ports || out_ctrl !== mon_e.ctrl || out_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL stream_word: got wr=%b ctrl=%h data=%h, required wr=%b ctrl=%h data=%h",
                             out_wr, out_ctrl, out_data, mon_e.ports, mon_e.ctrl, mon_e.data);
                end
            end
            for (int p = 0; p < NQ; p++) if (out_wr[p]) recv_cnt[p]++;
        end
    end

    task automatic write_word(input logic [CW-1:0] c, input logic [DW-1:0] d);
        int w;
        w = 0;
        while (!in_rdy && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_rdy_timeout: in_rdy=%b after %0d cycles, required 1", in_rdy, w);
        end
        in_ctrl = c;
        in_data = d;
        in_wr = 1'b1;
        last_wr_cyc = cyc;
        n_writes++;
        @(posedge clk); #1;
        in_wr = 1'b0;
    endtask

    // Writes up to max_words of a packet; expectations are queued only for words actually written.
    task automatic send_pkt(input logic [CW-1:0] hctrl, input logic [NQ-1:0] bitmap,
                            input int npay, input int max_words);
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic [NQ-1:0] fwd_ports;
        int nw;
        fwd_ports = (hctrl == IO_QUEUE_STAGE_NUM && bitmap != '0) ? bitmap : '0;
        nw = 0;
        for (int i = 0; i < npay + 2 && i < max_words; i++) begin
            d = {$urandom, $urandom};
            if (i == 0) begin
                c = hctrl;
                d[IOQ_DST_PORT_POS +: NQ] = bitmap;
            end else if (i == npay + 1) begin
                c = 8'h10;
            end else begin
                c = '0;
            end
            if (fwd_ports != '0) sb.push_back({fwd_ports, c, d});
            write_word(c, d);
            if (i == 0) hdr_cyc = last_wr_cyc;
            nw++;
        end
        if (nw == npay + 2) begin
            if (fwd_ports == '0) model_drop++;
            for (int p = 0; p < NQ; p++) if (fwd_ports[p]) model_pkt[p]++;
        end
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d words undelivered, required 0", name, sb.size());
            sb.delete();
        end
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_wr = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_rdy = '1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_wr !== '0) begin n_fail++; $display("FAIL reset_out_wr: got %b, required 0", out_wr); end
        n_tests++;
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
        n_tests++;
        if (out_ctrl !== '0) begin n_fail++; $display("FAIL reset_out_ctrl: got %h, required 0", out_ctrl); end
        n_tests++;
        if (drop_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
        n_tests++;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy: got %b, required 1", in_rdy); end
`ifdef DST_PORT_DEMUX_STATS_EN
        n_tests++;
        if (pkt_cnt !== '0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %h, required 0", pkt_cnt); end
`endif
        @(posedge clk); #1;
        $display("[TB] reset: done");
    endtask

    task automatic test_unicast();
        int base [NQ];
        int first_cyc;
        int w;
        base = recv_cnt;
        first_cyc = -1;
        fork
            send_pkt(IO_QUEUE_STAGE_NUM, 8'b0000_0100, 8, 99);
            begin
                w = 0;
                @(negedge clk);
                while (out_wr == '0 && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                if (out_wr != '0) first_cyc = cyc;
            end
        join
        n_tests++;
        if (first_cyc != hdr_cyc + 3) begin
            n_fail++;
            $display("FAIL unicast_latency: first strobe cycle %0d, required %0d", first_cyc, hdr_cyc + 3);
        end
        wait_idle("unicast");
        n_tests++;
        if (recv_cnt[2] - base[2] != 10) begin
            n_fail++;
            $display("FAIL unicast_words: port2 got %0d words, required 10", recv_cnt[2] - base[2]);
        end
`ifdef DST_PORT_DEMUX_STATS_EN
        n_tests++;
        if (pkt_cnt[32*2 +: 32] !== 32'(model_pkt[2])) begin
            n_fail++;
            $display("FAIL unicast_pkt_cnt: got %0d, required %0d", pkt_cnt[32*2 +: 32], model_pkt[2]);
        end
`endif
        $display("[TB] unicast: port2 words=%0d first strobe at T+%0d", recv_cnt[2] - base[2], first_cyc - hdr_cyc);
    endtask

    task automatic test_multicast_stall();
        int base [NQ];
        int strobes;
        int w;
        base = recv_cnt;
        strobes = -1;
        fork
            send_pkt(IO_QUEUE_STAGE_NUM, 8'b0001_0001, 8, 99);
            begin
                w = 0;
                @(negedge clk);
                while (out_wr == '0 && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                repeat (3) @(posedge clk);
                #1;
                out_rdy[4] = 1'b0;
                strobes = 0;
                @(negedge clk);
                repeat (4) begin
                    @(negedge clk);
                    if (out_wr != '0) strobes++;
                end
                @(posedge clk); #1;
                out_rdy[4] = 1'b1;
                @(negedge clk);
                if (out_wr != '0) strobes++;
                @(posedge clk); #1;
            end
        join
        n_tests++;
        if (strobes != 0) begin
            n_fail++;
            $display("FAIL multicast_stall: %0d strobes while port4 not ready, required 0", strobes);
        end
        wait_idle("multicast");
        n_tests++;
        if (recv_cnt[0] - base[0] != 10 || recv_cnt[4] - base[4] != 10) begin
            n_fail++;
            $display("FAIL multicast_words: port0=%0d port4=%0d, required 10 each",
                     recv_cnt[0] - base[0], recv_cnt[4] - base[4]);
        end
`ifdef DST_PORT_DEMUX_STATS_EN
        n_tests++;
        if (pkt_cnt[32*4 +: 32] !== 32'(model_pkt[4])) begin
            n_fail++;
            $display("FAIL multicast_pkt_cnt: port4 got %0d, required %0d", pkt_cnt[32*4 +: 32], model_pkt[4]);
        end
`endif
        $display("[TB] multicast_stall: port0=%0d port4=%0d stall strobes=%0d",
                 recv_cnt[0] - base[0], recv_cnt[4] - base[4], strobes);
    endtask

    task automatic test_zero_bitmap();
        int base [NQ];
        base = recv_cnt;
        send_pkt(IO_QUEUE_STAGE_NUM, 8'b0000_0000, 4, 99);
        send_pkt(IO_QUEUE_STAGE_NUM, 8'b0100_0000, 3, 99);
        wait_idle("zero_bitmap");
        n_tests++;
        if (drop_cnt !== 32'(model_drop)) begin
            n_fail++;
            $display("FAIL zero_bitmap_drop_cnt: got %0d, required %0d", drop_cnt, model_drop);
        end
        n_tests++;
        if (recv_cnt[6] - base[6] != 5) begin
            n_fail++;
            $display("FAIL zero_bitmap_next_pkt: port6 got %0d words, required 5", recv_cnt[6] - base[6]);
        end
        $display("[TB] zero_bitmap: drop_cnt=%0d next packet words=%0d", drop_cnt, recv_cnt[6] - base[6]);
    endtask

    task automatic test_malformed();
        int base [NQ];
        base = recv_cnt;
        send_pkt(8'h01, 8'b0000_0010, 5, 99);
        wait_idle("malformed");
        n_tests++;
        if (drop_cnt !== 32'(model_drop)) begin
            n_fail++;
            $display("FAIL malformed_drop_cnt: got %0d, required %0d", drop_cnt, model_drop);
        end
        n_tests++;
        if (recv_cnt[1] != base[1]) begin
            n_fail++;
            $display("FAIL malformed_forwarded: port1 got %0d words, required 0", recv_cnt[1] - base[1]);
        end
        $display("[TB] malformed: drop_cnt=%0d", drop_cnt);
    endtask

    task automatic test_back_pressure();
        int base [NQ];
        int wbase;
        int accepted;
        int held;
        int w;
        base = recv_cnt;
        wbase = n_writes;
        accepted = -1;
        held = -1;
        out_rdy = '0;
        fork
            send_pkt(IO_QUEUE_STAGE_NUM, 8'b1000_0010, 6, 99);
            begin
                w = 0;
                while (in_rdy && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                accepted = n_writes - wbase;
                repeat (5) @(negedge clk);
                held = in_rdy ? -2 : n_writes - wbase;
                @(posedge clk); #1;
                out_rdy = '1;
            end
        join
        n_tests++;
        if (accepted != 7) begin
            n_fail++;
            $display("FAIL bp_nearly_full: in_rdy fell after %0d words, required 7", accepted);
        end
        n_tests++;
        if (held != 7) begin
            n_fail++;
            $display("FAIL bp_hold: accepted count while stalled %0d, required 7 with in_rdy low", held);
        end
        wait_idle("back_pressure");
        n_tests++;
        if (recv_cnt[1] - base[1] != 8 || recv_cnt[7] - base[7] != 8) begin
            n_fail++;
            $display("FAIL bp_words: port1=%0d port7=%0d, required 8 each",
                     recv_cnt[1] - base[1], recv_cnt[7] - base[7]);
        end
        $display("[TB] back_pressure: in_rdy low after %0d words, delivered %0d", accepted, recv_cnt[1] - base[1]);
    endtask

    task automatic test_reset_mid_packet();
        int base [NQ];
        int w;
        send_pkt(IO_QUEUE_STAGE_NUM, 8'b0001_0001, 8, 4);
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_prefix: %0d words undelivered, required 0", sb.size());
            sb.delete();
        end
        // Leave three payload words stranded in the FIFO, then reset in the cycle they would fire.
        out_rdy = '0;
        for (int i = 0; i < 3; i++) write_word('0, {$urandom, $urandom});
        out_rdy = '1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (out_wr !== '0) begin n_fail++; $display("FAIL midrst_out_wr: got %b, required 0", out_wr); end
        n_tests++;
        if (drop_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_drop_cnt: got %0d, required 0", drop_cnt); end
`ifdef DST_PORT_DEMUX_STATS_EN
        n_tests++;
        if (pkt_cnt !== '0) begin n_fail++; $display("FAIL midrst_pkt_cnt: got %h, required 0", pkt_cnt); end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        model_drop = 0;
        foreach (model_pkt[i]) model_pkt[i] = 0;
        base = recv_cnt;
        send_pkt(IO_QUEUE_STAGE_NUM, 8'b0000_1000, 5, 99);
        wait_idle("midrst_next");
        n_tests++;
        if (recv_cnt[3] - base[3] != 7 || drop_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_next_pkt: port3=%0d drop_cnt=%0d, required 7 and 0", recv_cnt[3] - base[3], drop_cnt);
        end
        $display("[TB] reset_mid_packet: next packet words=%0d drop_cnt=%0d", recv_cnt[3] - base[3], drop_cnt);
    endtask

    task automatic test_back_to_back();
        send_pkt(IO_QUEUE_STAGE_NUM, 8'b0010_0000, 1, 99);
        send_pkt(IO_QUEUE_STAGE_NUM, 8'b0000_0011, 3, 99);
        send_pkt(IO_QUEUE_STAGE_NUM, 8'b0000_0000, 2, 99);
        send_pkt(IO_QUEUE_STAGE_NUM, 8'b1111_1111, 2, 99);
        wait_idle("back_to_back");
        n_tests++;
        if (drop_cnt !== 32'(model_drop)) begin
            n_fail++;
            $display("FAIL b2b_drop_cnt: got %0d, required %0d", drop_cnt, model_drop);
        end
`ifdef DST_PORT_DEMUX_STATS_EN
        for (int p = 0; p < NQ; p++) begin
            n_tests++;
            if (pkt_cnt[32*p +: 32] !== 32'(model_pkt[p])) begin
                n_fail++;
                $display("FAIL b2b_pkt_cnt: port%0d got %0d, required %0d", p, pkt_cnt[32*p +: 32], model_pkt[p]);
            end
        end
`endif
        $display("[TB] back_to_back: drop_cnt=%0d", drop_cnt);
    endtask

    initial begin
        foreach (model_pkt[i]) model_pkt[i] = 0;
        foreach (recv_cnt[i]) recv_cnt[i] = 0;
        test_reset();
        test_unicast();
        test_multicast_stall();
        test_zero_bitmap();
        test_malformed();
        test_back_pressure();
        test_reset_mid_packet();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dst_port_demux.md
# dst_port_demux

Egress-side consumer of the IOQ module header: accepts the shared 64-bit packet stream after output-port lookup and steers each packet to the output queues selected by the destination-port bitmap carried in that header. The block sits between the lookup stage and the per-port output-queue writers. It provides multicast (several bitmap bits set), drop of zero-destination and malformed packets, and optional per-port packet counters. One shared registered data/ctrl bus is qualified by a per-port write-enable vector.

## Interface
- DATA_WIDTH, 64, datapath width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width.
- NUM_OUTPUT_QUEUES, 8, number of output ports; one bitmap bit per port.
- IN_FIFO_DEPTH_BITS, 3, log2 depth of the input FIFO.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  DATA_WIDTH  input word.
- in_ctrl  in  CTRL_WIDTH  input ctrl; 0 = payload word.
- in_wr  in  1  input word valid.
- in_rdy  out  1  input FIFO not nearly full.
- out_data  out  DATA_WIDTH  registered shared output word.
- out_ctrl  out  CTRL_WIDTH  registered shared output ctrl.
- out_wr  out  NUM_OUTPUT_QUEUES  per-port write strobe.
- out_rdy  in  NUM_OUTPUT_QUEUES  per-port ready; high means the port can take at least one more word.
- drop_cnt  out  32  packets dropped; wraps.
- pkt_cnt  out  32*NUM_OUTPUT_QUEUES  per-port forwarded packets; exists only with the stats macro.

## Operation
- The input FIFO (small_fifo, width DATA_WIDTH+CTRL_WIDTH) absorbs in_wr words. Upstream must not write while in_rdy is low.
- Packet format: module-header words (ctrl≠0), then payload words (ctrl=0), then an EOP word (ctrl≠0 following payload). The first word must be the IOQ header (ctrl == IO_QUEUE_STAGE_NUM).
- FSM states: WAIT_HDR, SEND_HDRS, SEND_DATA, DROP_HDRS, DROP_DATA.
- WAIT_HDR, FIFO head is the IOQ header:
  - sel ← head_data[IOQ_DST_PORT_POS+NUM_OUTPUT_QUEUES-1 : IOQ_DST_PORT_POS]; higher bitmap bits are ignored.
  - sel≠0 → SEND_HDRS, without consuming the word.
  - sel==0 → DROP_HDRS.
- WAIT_HDR, head ctrl ≠ IO_QUEUE_STAGE_NUM → DROP_HDRS (malformed packet).
- Fire condition: FIFO not empty and every selected port ready, i.e. &(out_rdy | ~sel). On fire:
  - pop the FIFO;
  - register the word onto out_data/out_ctrl;
  - out_wr ← sel on the next cycle; unselected ports stay 0.
  - A single slow selected port stalls all selected ports. No partial multicast is performed.
- SEND_HDRS: fire each word; a word with ctrl==0 moves the FSM to SEND_DATA.
- SEND_DATA: fire each word; when the fired word has ctrl≠0 (EOP):
  - increment pkt_cnt[p] for every p in sel;
  - return to WAIT_HDR.
- DROP_HDRS / DROP_DATA: same sequencing, but pop without waiting on out_rdy and assert no out_wr. On EOP, drop_cnt += 1 and return to WAIT_HDR.
- The IOQ header is forwarded unmodified.

## Timing
- Reset values: out_wr=0, out_data=0, out_ctrl=0, state=WAIT_HDR, drop_cnt=0, pkt_cnt=0, FIFO empty, in_rdy=1 from the cycle after reset deasserts.
- Reset mid-packet: FIFO flushed and FSM back to WAIT_HDR. The partial packet is lost and not counted.
- Latency, empty FIFO with all ports ready:
  - in_wr at cycle T;
  - word at FIFO head at T+1;
  - WAIT_HDR decodes at T+1;
  - first fire at T+2;
  - out_wr asserted at T+3.
  - Afterwards, one word per cycle while the fire condition holds.
- Inter-packet gap: 1 idle cycle (WAIT_HDR decode), no bubble between words inside a packet.
- out_rdy is sampled in the fire cycle. The registered word in flight is covered by the downstream nearly-full convention.
- in_rdy = !nearly_full; nearly_full asserts at depth-1 entries.
- Simultaneous in_wr and pop on a full-minus-one FIFO is legal.
- A counter increment and EOP in the same cycle is a single increment.
- Counters wrap at 2^32.

## Configuration
- DST_PORT_DEMUX_STATS_EN:
  - Defined: pkt_cnt port and per-port counters are present.
  - Undefined: pkt_cnt port and counter logic are absent.
- drop_cnt and all forwarding behaviour are identical in both builds.

## Structure
- IO_QUEUE_STAGE_NUM, IOQ_DST_PORT_POS and the FSM state encodings live in the shared NetFPGA defines package; this block defines no local copies.
- Input buffering reuses the existing small_fifo.
- One natural sub-module: dst_port_demux_stats (per-port counter bank, instantiated only under the macro).

## Test plan
- Unicast: IOQ bitmap 8'b0000_0100, 1 header + 8 payload + EOP, all ready → 10 words on out_wr[2] only, first strobe at T+3; pkt_cnt[2]=1.
- Multicast stall: bitmap 8'b0001_0001, out_rdy[4] low for 5 cycles mid-payload → no out_wr on any port during the stall; both ports receive an identical 10-word sequence.
- Zero bitmap: bitmap 0 → no out_wr, drop_cnt=1, next packet forwarded normally.
- Malformed: first word ctrl=8'h01 → whole packet dropped through EOP, drop_cnt=1.
- Back-pressure: all out_rdy low while 8 words are written → in_rdy deasserts at nearly-full, no FIFO overflow, all words later delivered in order.
- Reset after 4 words of a multicast packet → out_wr=0 the next cycle, counters 0, the following packet delivered intact.
